alu_sequencer: RTL and testbench

//  Multi-cycle controller that sequences the 3-bit-opcode 32-bit ALU against a small register file.

---
 rtl/alu_seq_pkg.sv | 26 ++
 rtl/alu_seq_regfile.sv | 49 ++++
 rtl/alu_sequencer.sv | 171 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared widths, opcodes and FSM state encoding for the ALU sequencer.
package alu_seq_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned OP_W     = 3;

  localparam logic [OP_W-1:0] OP_PASS = 3'b000;
  localparam logic [OP_W-1:0] OP_NOT  = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b011;
  localparam logic [OP_W-1:0] OP_OR   = 3'b100;
  localparam logic [OP_W-1:0] OP_AND  = 3'b101;
  localparam logic [OP_W-1:0] OP_SLT  = 3'b110;
  localparam logic [OP_W-1:0] OP_ILL  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_WB   = 3'd3,
    S_RESP = 3'd4
  } state_e;

endpackage

// File: rtl/alu_seq_regfile.sv
// Register file: two async read ports, one debug read port, one sync write port.
// Entry 0 is hardwired to zero; the whole array clears on async reset.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int unsigned N    = DATA_W,
  parameter int unsigned NREG = NUM_REGS,
  parameter int unsigned AW   = ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [N-1:0]  rdata_a_c,
  input  logic [AW-1:0] raddr_b,
  output logic [N-1:0]  rdata_b_c,
  input  logic [AW-1:0] dbg_addr,
  output logic [N-1:0]  dbg_data_c
);

  logic [N-1:0] mem_q [NREG];
  logic [N-1:0] mem_d [NREG];

  // Next-state: single write, entry 0 forced to zero.
  always_comb begin
    mem_d = mem_q;
    if (we && (waddr != '0)) begin
      mem_d[waddr] = wdata;
    end
    mem_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_a_c  = (raddr_a  == '0) ? '0 : mem_q[raddr_a];
  assign rdata_b_c  = (raddr_b  == '0) ? '0 : mem_q[raddr_b];
  assign dbg_data_c = (dbg_addr == '0) ? '0 : mem_q[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle controller: accepts one reg-reg instruction, drives the external
// combinational ALU, writes the result back and returns it on a response handshake.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned N    = DATA_W,
  parameter int unsigned NREG = NUM_REGS,
  parameter int unsigned AW   = ADDR_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [OP_W-1:0] instr_op,
  input  logic [AW-1:0]   instr_rd,
  input  logic [AW-1:0]   instr_rs,
  input  logic [AW-1:0]   instr_rt,
  output logic [N-1:0]    alu_a,
  output logic [N-1:0]    alu_b,
  output logic [OP_W-1:0] alu_op,
  input  logic [N-1:0]    alu_result,
  output logic            done_valid,
  input  logic            done_ready,
  output logic [N-1:0]    done_data,
  output logic            done_err,
  input  logic [AW-1:0]   dbg_addr,
  output logic [N-1:0]    dbg_data
);

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW-1:0]   rs_q, rs_d;
  logic [AW-1:0]   rt_q, rt_d;
  logic [N-1:0]    alu_a_q, alu_a_d;
  logic [N-1:0]    alu_b_q, alu_b_d;
  logic [OP_W-1:0] alu_op_q, alu_op_d;
  logic [N-1:0]    result_q, result_d;
  logic            done_valid_q, done_valid_d;
  logic [N-1:0]    done_data_q, done_data_d;
  logic            done_err_q, done_err_d;
  logic            instr_ready_q, instr_ready_d;

  logic            rf_we_c;
  logic [N-1:0]    rf_rdata_a_c;
  logic [N-1:0]    rf_rdata_b_c;

  alu_seq_regfile #(
    .N    (N),
    .NREG (NREG),
    .AW   (AW)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (rf_we_c),
    .waddr      (rd_q),
    .wdata      (result_q),
    .raddr_a    (rs_q),
    .rdata_a_c  (rf_rdata_a_c),
    .raddr_b    (rt_q),
    .rdata_b_c  (rf_rdata_b_c),
    .dbg_addr   (dbg_addr),
    .dbg_data_c (dbg_data)
  );

  // Sequencing: IDLE -> READ -> EXEC -> WB -> RESP -> IDLE; illegal ops skip to RESP.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rd_d         = rd_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    result_d     = result_q;
    done_valid_d = done_valid_q;
    done_data_d  = done_data_q;
    done_err_d   = done_err_q;
    rf_we_c      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (instr_valid && instr_ready_q) begin
          op_d = instr_op;
          rd_d = instr_rd;
          rs_d = instr_rs;
          rt_d = instr_rt;
          if (instr_op == OP_ILL) begin
            done_valid_d = 1'b1;
            done_err_d   = 1'b1;
            done_data_d  = '0;
            state_d      = S_RESP;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        alu_a_d  = rf_rdata_a_c;
        alu_b_d  = rf_rdata_b_c;
        alu_op_d = op_q;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        result_d = alu_result;
        state_d  = S_WB;
      end
      S_WB: begin
        rf_we_c      = 1'b1;
        done_data_d  = result_q;
        done_err_d   = 1'b0;
        done_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (done_ready) begin
          done_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Ready is a registered decode of the next state.
    instr_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      op_q          <= '0;
      rd_q          <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      result_q      <= '0;
      done_valid_q  <= 1'b0;
      done_data_q   <= '0;
      done_err_q    <= 1'b0;
      instr_ready_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      rd_q          <= rd_d;
      rs_q          <= rs_d;
      rt_q          <= rt_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      result_q      <= result_d;
      done_valid_q  <= done_valid_d;
      done_data_q   <= done_data_d;
      done_err_q    <= done_err_d;
      instr_ready_q <= instr_ready_d;
    end
  end

  assign instr_ready = instr_ready_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign done_valid  = done_valid_q;
  assign done_data   = done_data_q;
  assign done_err    = done_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: the bench plays the external ALU and
// keeps an architectural register-file model to predict every response.
module tb_alu_sequencer;

  localparam logic [2:0] T_PASS = 3'b000;
  localparam logic [2:0] T_NOT  = 3'b001;
  localparam logic [2:0] T_ADD  = 3'b010;
  localparam logic [2:0] T_SUB  = 3'b011;
  localparam logic [2:0] T_SLT  = 3'b110;
  localparam logic [2:0] T_ILL  = 3'b111;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  instr_op;
  logic [2:0]  instr_rd;
  logic [2:0]  instr_rs;
  logic [2:0]  instr_rt;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;
  logic        done_valid;
  logic        done_ready;
  logic [31:0] done_data;
  logic        done_err;
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rf_m [8];

  alu_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_rd    (instr_rd),
    .instr_rs    (instr_rs),
    .instr_rt    (instr_rt),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .done_data   (done_data),
    .done_err    (done_err),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Architectural meaning of each opcode on signed/unsigned 32-bit integers.
  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    int signed sa;
    int signed sb;
    sa = a;
    sb = b;
    case (op)
      T_PASS:  return a;
      T_NOT:   return 32'hFFFF_FFFF ^ a;
      T_ADD:   return 32'(longint'(a) + longint'(b));
      T_SUB:   return 32'(longint'(a) - longint'(b));
      3'b100:  return a | b;
      3'b101:  return a & b;
      T_SLT:   return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // External ALU stand-in.
  always_comb alu_result = ref_op(alu_op, alu_a, alu_b);

  task automatic clear_model();
    for (int i = 0; i < 8; i++) rf_m[i] = 32'd0;
  endtask

  task automatic check_rf(input string name);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      checks++;
      if (dbg_data !== rf_m[i]) begin
        failures++;
        $display("FAIL %s rf[%0d]: got %h want %h", name, i, dbg_data, rf_m[i]);
      end
    end
  endtask

  // Issue one instruction, optionally stall the response, and check everything.
  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [2:0] rt, input int stall, input string name);
    logic [31:0] exp;
    logic        exp_err;
    int          lat;
    exp_err = (op == T_ILL);
    exp     = exp_err ? 32'd0 : ref_op(op, rf_m[rs], rf_m[rt]);
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_before: got %b want 1", name, instr_ready);
    end
    instr_valid = 1'b1;
    instr_op    = op;
    instr_rd    = rd;
    instr_rs    = rs;
    instr_rt    = rt;
    done_ready  = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    instr_op    = 3'($urandom);
    instr_rd    = 3'($urandom);
    instr_rs    = 3'($urandom);
    instr_rt    = 3'($urandom);
    lat = 1;
    while (done_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != (exp_err ? 1 : 4)) begin
      failures++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, exp_err ? 1 : 4);
    end
    checks++;
    if (done_data !== exp || done_err !== exp_err) begin
      failures++;
      $display("FAIL %s result: got data=%h err=%b want data=%h err=%b",
               name, done_data, done_err, exp, exp_err);
    end
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (done_valid !== 1'b1 || done_data !== exp || done_err !== exp_err ||
          instr_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s stall%0d: got v=%b data=%h err=%b rdy=%b want v=1 data=%h err=%b rdy=0",
                 name, s, done_valid, done_data, done_err, instr_ready, exp, exp_err);
      end
      instr_valid = 1'($urandom);
      instr_op    = 3'($urandom);
      instr_rd    = 3'($urandom_range(1, 7));
    end
    instr_valid = 1'b0;
    done_ready  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (done_valid !== 1'b0 || instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s after_resp: got v=%b rdy=%b want v=0 rdy=1", name, done_valid, instr_ready);
    end
    if (!exp_err && rd != 3'd0) rf_m[rd] = exp;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr_op    = 3'd0;
    instr_rd    = 3'd0;
    instr_rs    = 3'd0;
    instr_rt    = 3'd0;
    done_ready  = 1'b1;
    dbg_addr    = 3'd0;
    clear_model();
    #13;
    checks++;
    if (instr_ready !== 1'b1 || done_valid !== 1'b0 || done_data !== 32'd0 ||
        done_err !== 1'b0 || alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 3'd0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b v=%b d=%h e=%b a=%h b=%h op=%b want rdy=1 rest 0",
               instr_ready, done_valid, done_data, done_err, alu_a, alu_b, alu_op);
    end
    check_rf("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_path();
    issue(T_NOT, 3'd1, 3'd0, 3'd0, 0, "not_r1");
    check_rf("not_r1");
    issue(T_SUB, 3'd2, 3'd0, 3'd1, 0, "sub_r2");
    issue(T_ADD, 3'd3, 3'd2, 3'd2, 0, "add_r3");
    check_rf("load");
  endtask

  task automatic test_wrap_signed();
    issue(T_ADD, 3'd4, 3'd1, 3'd2, 0, "add_wrap");
    issue(T_SLT, 3'd5, 3'd1, 3'd2, 0, "slt_neg");
    issue(T_SLT, 3'd6, 3'd2, 3'd1, 0, "slt_pos");
    check_rf("wrap_signed");
  endtask

  task automatic test_illegal_zero();
    issue(T_ILL, 3'd3, 3'd1, 3'd2, 0, "illegal");
    check_rf("illegal");
    issue(T_ADD, 3'd0, 3'd3, 3'd3, 0, "add_r0");
    check_rf("zero_reg");
  endtask

  task automatic test_backpressure();
    issue(T_ADD, 3'd4, 3'd3, 3'd2, 10, "backpressure");
    check_rf("backpressure");
  endtask

  task automatic test_abort();
    int seen;
    @(negedge clk);
    instr_valid = 1'b1;
    instr_op    = T_ADD;
    instr_rd    = 3'd7;
    instr_rs    = 3'd3;
    instr_rt    = 3'd3;
    done_ready  = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    clear_model();
    checks++;
    if (done_valid !== 1'b0 || instr_ready !== 1'b1 || alu_a !== 32'd0 || alu_op !== 3'd0) begin
      failures++;
      $display("FAIL abort_reset: got v=%b rdy=%b a=%h op=%b want v=0 rdy=1 a=0 op=0",
               done_valid, instr_ready, alu_a, alu_op);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL abort_no_resp: got %0d valid cycles want 0", seen);
    end
    check_rf("abort");
  endtask

  task automatic test_random();
    logic [2:0] op;
    issue(T_NOT, 3'd1, 3'd0, 3'd0, 0, "reload1");
    issue(T_SUB, 3'd2, 3'd0, 3'd1, 0, "reload2");
    issue(T_ADD, 3'd3, 3'd2, 3'd2, 1, "reload3");
    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom);
      issue(op, 3'($urandom), 3'($urandom), 3'($urandom), int'($urandom_range(0, 3)), "random");
    end
    check_rf("random");
  endtask

  initial begin
    test_reset();
    test_load_path();
    test_wrap_signed();
    test_illegal_zero();
    test_backpressure();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
